// File: rtl/fft_ram_port_ctrl_if.sv
// FFT-side RAM port plus the sample/result streams between the sequencer and the FFT core.
interface fft_ram_port_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] ram_read_addr;
  logic              ram_write_to_cache;
  logic [15:0]       ram_read_data;
  logic [ADDR_W-1:0] ram_send_addr;
  logic [31:0]       ram_send_data;
  logic [15:0]       smp_data;
  logic              smp_valid;
  logic              smp_ready;
  logic [31:0]       res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output ram_read_addr, ram_write_to_cache, ram_send_addr, ram_send_data,
    input  ram_read_data,
    output smp_data, smp_valid,
    input  smp_ready,
    input  res_data, res_valid,
    output res_ready
  );

  modport slave (
    input  ram_read_addr, ram_write_to_cache, ram_send_addr, ram_send_data,
    output ram_read_data,
    input  smp_data, smp_valid,
    output smp_ready,
    output res_data, res_valid,
    input  res_ready
  );
endinterface

// File: rtl/fft_ram_port_ctrl.sv
// FFT-side RAM sequencer: streams a frame of samples out through a 3-deep skid FIFO,
// then writes the core's results back on the RAM's 2-cycle-delayed write path.
module fft_ram_port_ctrl #(
  parameter int N_LOG2       = 10,
  parameter int ADDR_W       = 12,
  parameter int SCRATCH_ADDR = 4095
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                bitrev_i,
  input  logic [ADDR_W-1:0]   in_base_i,
  input  logic [ADDR_W-1:0]   out_base_i,
  output logic                busy_o,
  output logic                done_o,
  fft_ram_port_ctrl_if.master bus
);
  localparam int                N       = 1 << N_LOG2;
  localparam int                CW      = N_LOG2 + 1;
  localparam logic [CW-1:0]     LAST    = CW'(N - 1);
  localparam logic [ADDR_W-1:0] SCRATCH = ADDR_W'(SCRATCH_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FLUSH} state_t;

  state_t            state_q, state_d;
  logic              bitrev_q;
  logic [ADDR_W-1:0] in_base_q, out_base_q;
  logic [CW-1:0]     rk_q, rk_d, pk_q, pk_d, wk_q, wk_d;
  logic [1:0]        flush_q, flush_d;
  logic              inflight_q;
  logic [15:0]       fifo_q [3];
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ_q, occ_d;
  logic [31:0]       pipe1_q, pipe1_d, pipe2_q;
  logic [N_LOG2-1:0] rk_rev, rd_off;
  logic              rd_issue, push, pop, wr_hs;

  for (genvar gi = 0; gi < N_LOG2; gi++) begin : g_rev
    assign rk_rev[gi] = rk_q[N_LOG2-1-gi];
  end

  // Data path: a read is only issued while a FIFO slot is guaranteed for its data.
  always_comb begin
    rd_off   = bitrev_q ? rk_rev : rk_q[N_LOG2-1:0];
    rd_issue = (state_q == LOAD) && (rk_q < CW'(N))
               && ((3'(occ_q) + 3'(inflight_q)) < 3'd3);
    push     = inflight_q;
    pop      = (occ_q != 2'd0) && bus.smp_ready;
    wr_hs    = (state_q == STORE) && bus.res_valid;

    occ_d    = occ_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    pipe1_d  = wr_hs ? bus.res_data : 32'd0;

    bus.ram_write_to_cache = rd_issue;
    bus.ram_read_addr      = rd_issue ? in_base_q + ADDR_W'(rd_off) : '0;
    bus.smp_valid          = (occ_q != 2'd0);
    bus.smp_data           = bus.smp_valid ? fifo_q[rd_ptr_q] : 16'd0;
    bus.res_ready          = (state_q == STORE);
    bus.ram_send_addr      = wr_hs ? out_base_q + ADDR_W'(wk_q) : SCRATCH;
    bus.ram_send_data      = pipe2_q;
    busy_o                 = (state_q != IDLE);
  end

  // FLUSH waits out the write pipe; its third cycle carries the done pulse.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    pk_d    = pk_q;
    wk_d    = wk_q;
    flush_d = flush_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        rk_d    = '0;
        pk_d    = '0;
        wk_d    = '0;
        flush_d = '0;
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        if (rd_issue) rk_d = rk_q + 1'b1;
        if (pop) begin
          pk_d = pk_q + 1'b1;
          if (pk_q == LAST) state_d = STORE;
        end
      end
      STORE: begin
        if (wr_hs) begin
          wk_d = wk_q + 1'b1;
          if (wk_q == LAST) state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_d = flush_q + 2'd1;
        if (flush_q == 2'd2) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitrev_q   <= 1'b0;
      in_base_q  <= '0;
      out_base_q <= '0;
      rk_q       <= '0;
      pk_q       <= '0;
      wk_q       <= '0;
      flush_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      pipe1_q    <= '0;
      pipe2_q    <= '0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rk_q       <= rk_d;
      pk_q       <= pk_d;
      wk_q       <= wk_d;
      flush_q    <= flush_d;
      inflight_q <= rd_issue;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pipe1_q    <= pipe1_d;
      pipe2_q    <= pipe1_q;
      if (push) fifo_q[wr_ptr_q] <= bus.ram_read_data;
      if ((state_q == IDLE) && start_i) begin
        bitrev_q   <= bitrev_i;
        in_base_q  <= in_base_i;
        out_base_q <= out_base_i;
      end
    end
  end
endmodule

// File: tb/tb_fft_ram_port_ctrl.sv
// Bench for fft_ram_port_ctrl: RAM model with 2-flop write-address delay, frame
// vectors from a table, randomized frames, and a reset-during-load sequence.
module tb_fft_ram_port_ctrl;
  localparam int              NL  = 3;
  localparam int              N   = 1 << NL;
  localparam int              AW  = 12;
  localparam logic [AW-1:0]   SCR = 12'hFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, bitrev_i;
  logic [AW-1:0] in_base_i, out_base_i;
  logic          busy_o, done_o;
  logic          mem_init;

  fft_ram_port_ctrl_if #(.ADDR_W(AW)) bus_if ();

  fft_ram_port_ctrl #(.N_LOG2(NL), .ADDR_W(AW), .SCRATCH_ADDR(4095)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .bitrev_i(bitrev_i),
    .in_base_i(in_base_i), .out_base_i(out_base_i),
    .busy_o(busy_o), .done_o(done_o), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // RAM model: registered read; write address delayed by two flops; reads inhibit writes.
  typedef struct {logic [AW-1:0] addr; logic [31:0] data; int c;} wr_t;
  wr_t           wr_q [$];
  logic [31:0]   mem [4096];
  logic [15:0]   rd_data_q;
  logic [AW-1:0] a1 = SCR, a2 = SCR;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= $urandom;
    end else begin
      rd_data_q <= mem[bus_if.ram_read_addr][15:0];
      a1 <= bus_if.ram_send_addr;
      a2 <= a1;
      if (!bus_if.ram_write_to_cache) begin
        mem[a2] <= bus_if.ram_send_data;
        if (a2 != SCR || bus_if.ram_send_data != 32'd0)
          wr_q.push_back('{a2, bus_if.ram_send_data, cyc});
      end
    end
  end
  assign bus_if.ram_read_data = rd_data_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_addr(input bit br, input logic [AW-1:0] base, input int k);
    int off = k;
    if (br) begin
      off = 0;
      for (int i = 0; i < NL; i++) off = off * 2 + ((k >> i) & 1);
    end
    return base + AW'(off);
  endfunction

  // Per-frame observations
  logic [AW-1:0] rd_log [$];
  int            rd_cyc [$];
  logic [15:0]   smp_log [$];
  int            pop_cyc [$];
  int            hs_cyc [$];
  int            max_out, viol, done_cyc, first_valid, first_rr;

  task automatic run_frame(input bit br, input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                           input int st_lo, input int st_hi, input bit rnd_ready,
                           input bit early, input bit rnd_res, input bit noise,
                           input logic [31:0] res [N]);
    int  ri = 0;
    int  outst;
    bit  done_seen = 0;
    bit  finished  = 0;
    bit  hs;
    @(posedge clk); #1;
    cyc = 0;
    rd_log.delete(); rd_cyc.delete(); smp_log.delete(); pop_cyc.delete(); hs_cyc.delete();
    wr_q.delete();
    max_out = 0; viol = 0; done_cyc = -1; first_valid = -1; first_rr = -1;
    start_i = 1'b1; bitrev_i = br; in_base_i = ib; out_base_i = ob;
    bus_if.smp_ready = 1'b0; bus_if.res_valid = 1'b0; bus_if.res_data = 32'd0;
    for (int k = 0; k < 600 && !finished; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (noise && !done_seen && $urandom_range(0, 3) == 0) begin
        start_i = 1'b1; bitrev_i = 1'($urandom); in_base_i = AW'($urandom); out_base_i = AW'($urandom);
      end else begin
        start_i = 1'b0;
      end
      if (rnd_ready) bus_if.smp_ready = ($urandom_range(0, 2) != 0);
      else           bus_if.smp_ready = !(cyc >= st_lo && cyc <= st_hi);
      bus_if.res_valid = (ri < N) && (early || smp_log.size() == N) && (!rnd_res || $urandom_range(0, 2) != 0);
      bus_if.res_data  = (ri < N) ? res[ri] : (32'hDEAD_0000 | 32'(cyc));
      @(negedge clk);
      if (done_seen) begin
        check("busy_low_after_done", busy_o, 1'b0);
        check("done_single_pulse", done_o, 1'b0);
        finished = 1;
      end else begin
        if (!busy_o) viol++;
        if (bus_if.ram_write_to_cache) begin
          rd_log.push_back(bus_if.ram_read_addr);
          rd_cyc.push_back(cyc);
        end
        outst = rd_log.size() - smp_log.size();
        if (outst > max_out) max_out = outst;
        if (bus_if.smp_valid && first_valid < 0) first_valid = cyc;
        if (bus_if.res_ready && first_rr < 0) first_rr = cyc;
        if (bus_if.res_ready && smp_log.size() < N) viol++;
        if (bus_if.res_ready && bus_if.ram_write_to_cache) viol++;
        hs = bus_if.res_valid && bus_if.res_ready;
        if (!hs && bus_if.ram_send_addr !== SCR) viol++;
        if (bus_if.smp_valid && bus_if.smp_ready) begin
          smp_log.push_back(bus_if.smp_data);
          pop_cyc.push_back(cyc);
        end
        if (hs) begin
          hs_cyc.push_back(cyc);
          ri++;
        end
        if (done_o) begin
          done_seen = 1;
          done_cyc  = cyc;
        end
      end
    end
    start_i = 1'b0;
    check("frame_completed", finished, 1'b1);
  endtask

  task automatic verify(input string tag, input bit br, input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                        input logic [31:0] res [N], input logic [15:0] exp_smp [N]);
    logic [AW-1:0] ea;
    check({tag, " read_count"}, rd_log.size(), N);
    check({tag, " sample_count"}, smp_log.size(), N);
    check({tag, " handshake_count"}, hs_cyc.size(), N);
    check({tag, " write_count"}, wr_q.size(), N);
    check({tag, " max_outstanding"}, max_out, 3);
    check({tag, " safety_violations"}, viol, 0);
    for (int k = 0; k < N; k++) begin
      if (k < rd_log.size())
        check($sformatf("%s read_addr[%0d]", tag, k), rd_log[k], model_addr(br, ib, k));
      if (k < smp_log.size())
        check($sformatf("%s sample[%0d]", tag, k), smp_log[k], exp_smp[k]);
      if (k < wr_q.size() && k < hs_cyc.size()) begin
        ea = ob + AW'(k);
        check($sformatf("%s write_addr[%0d]", tag, k), wr_q[k].addr, ea);
        check($sformatf("%s write_data[%0d]", tag, k), wr_q[k].data, res[k]);
        check($sformatf("%s write_cycle[%0d]", tag, k), wr_q[k].c, hs_cyc[k] + 2);
      end
    end
    if (hs_cyc.size() == N) check({tag, " done_cycle"}, done_cyc, hs_cyc[N-1] + 3);
    if (pop_cyc.size() == N) check({tag, " first_res_ready"}, first_rr, pop_cyc[N-1] + 1);
  endtask

  typedef struct {
    bit                     br;
    logic [AW-1:0]          ib, ob;
    int                     st_lo, st_hi;
    bit                     early, noise;
    logic [N-1:0][AW-1:0]   exp_addr;
    int                     exp_first_valid, exp_last_read, exp_last_pop;
  } vec_t;

  vec_t          vt [4];
  logic [31:0]   res [N];
  logic [15:0]   exp_smp [N];
  int            nrd;
  bit            r_br;
  logic [AW-1:0] r_ib, r_ob;

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    start_i = 1'b0; bitrev_i = 1'b0; in_base_i = '0; out_base_i = '0;
    bus_if.smp_ready = 1'b0; bus_if.res_valid = 1'b0; bus_if.res_data = '0;
    @(posedge clk); #1; mem_init = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst busy", busy_o, 1'b0);
    check("rst done", done_o, 1'b0);
    check("rst smp_valid", bus_if.smp_valid, 1'b0);
    check("rst res_ready", bus_if.res_ready, 1'b0);
    check("rst write_to_cache", bus_if.ram_write_to_cache, 1'b0);
    check("rst read_addr", bus_if.ram_read_addr, 12'h000);
    check("rst send_addr", bus_if.ram_send_addr, SCR);
    check("rst send_data", bus_if.ram_send_data, 32'd0);
    check("rst smp_data", bus_if.smp_data, 16'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    vt[0] = '{1'b0, 12'h100, 12'hFFE, 0, -1, 1'b0, 1'b0,
              {12'h107, 12'h106, 12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100}, 3, 8, 10};
    vt[1] = '{1'b1, 12'h000, 12'h200, 0, -1, 1'b0, 1'b1,
              {12'h007, 12'h003, 12'h005, 12'h001, 12'h006, 12'h002, 12'h004, 12'h000}, 3, 8, 10};
    vt[2] = '{1'b0, 12'h300, 12'h400, 4, 9, 1'b1, 1'b0,
              {12'h307, 12'h306, 12'h305, 12'h304, 12'h303, 12'h302, 12'h301, 12'h300}, 3, 14, 16};
    vt[3] = '{1'b1, 12'hFFC, 12'h010, 0, -1, 1'b0, 1'b1,
              {12'h003, 12'hFFF, 12'h001, 12'hFFD, 12'h002, 12'hFFE, 12'h000, 12'hFFC}, 3, 8, 10};

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < N; k++) begin
        res[k]     = 32'(v << 8) + 32'hA0 + 32'(k);
        exp_smp[k] = mem[model_addr(vt[v].br, vt[v].ib, k)][15:0];
      end
      run_frame(vt[v].br, vt[v].ib, vt[v].ob, vt[v].st_lo, vt[v].st_hi, 1'b0,
                vt[v].early, 1'b0, vt[v].noise, res);
      for (int k = 0; k < N; k++)
        if (k < rd_log.size())
          check($sformatf("vec%0d table_addr[%0d]", v, k), rd_log[k], vt[v].exp_addr[k]);
      if (rd_cyc.size() == N) begin
        check($sformatf("vec%0d first_read_cycle", v), rd_cyc[0], 1);
        check($sformatf("vec%0d last_read_cycle", v), rd_cyc[N-1], vt[v].exp_last_read);
      end
      check($sformatf("vec%0d first_valid_cycle", v), first_valid, vt[v].exp_first_valid);
      if (pop_cyc.size() == N)
        check($sformatf("vec%0d last_pop_cycle", v), pop_cyc[N-1], vt[v].exp_last_pop);
      verify($sformatf("vec%0d", v), vt[v].br, vt[v].ib, vt[v].ob, res, exp_smp);
      $display("vec%0d: bitrev=%0d in_base=0x%03h out_base=0x%03h done@%0d", v, vt[v].br, vt[v].ib, vt[v].ob, done_cyc);
      repeat (2) @(posedge clk);
    end

    for (int f = 0; f < 8; f++) begin
      r_br = 1'($urandom);
      r_ib = AW'($urandom);
      r_ob = AW'($urandom);
      for (int k = 0; k < N; k++) begin
        res[k]     = $urandom | 32'h1;
        exp_smp[k] = mem[model_addr(r_br, r_ib, k)][15:0];
      end
      run_frame(r_br, r_ib, r_ob, 0, -1, 1'b1, 1'($urandom), 1'b1, 1'b1, res);
      verify($sformatf("rnd%0d", f), r_br, r_ib, r_ob, res, exp_smp);
      $display("rnd%0d: bitrev=%0d in_base=0x%03h out_base=0x%03h done@%0d", f, r_br, r_ib, r_ob, done_cyc);
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    // Reset while the fifth read is about to issue, then a fresh frame.
    @(posedge clk); #1;
    start_i = 1'b1; bitrev_i = 1'b0; in_base_i = 12'h500; out_base_i = 12'h600;
    bus_if.smp_ready = 1'b1; bus_if.res_valid = 1'b0;
    nrd = 0;
    for (int k = 0; k < 20 && nrd < 4; k++) begin
      @(posedge clk); #1; start_i = 1'b0;
      @(negedge clk);
      if (bus_if.ram_write_to_cache) nrd++;
    end
    check("midload reads_before_reset", nrd, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midload rst busy", busy_o, 1'b0);
    check("midload rst smp_valid", bus_if.smp_valid, 1'b0);
    check("midload rst smp_data", bus_if.smp_data, 16'd0);
    check("midload rst write_to_cache", bus_if.ram_write_to_cache, 1'b0);
    check("midload rst read_addr", bus_if.ram_read_addr, 12'h000);
    check("midload rst send_addr", bus_if.ram_send_addr, SCR);
    check("midload rst send_data", bus_if.ram_send_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst busy", busy_o, 1'b0);
    check("post_rst smp_valid", bus_if.smp_valid, 1'b0);
    for (int k = 0; k < N; k++) begin
      res[k]     = 32'h5500 + 32'(k);
      exp_smp[k] = mem[model_addr(1'b0, 12'h500, k)][15:0];
    end
    run_frame(1'b0, 12'h500, 12'h600, 0, -1, 1'b0, 1'b0, 1'b0, 1'b1, res);
    verify("after_reset", 1'b0, 12'h500, 12'h600, res, exp_smp);
    $display("after_reset: in_base=0x500 out_base=0x600 done@%0d", done_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_ram_port_ctrl.md
# fft_ram_port_ctrl

Sequencer that drives the FFT-side port of the sample/result RAM. On `start` it reads a frame of N 16-bit samples from the RAM in natural or bit-reversed order and streams them to the FFT core through a valid/ready skid buffer. It then accepts N 32-bit results from the core and writes them back through the RAM's 2-cycle-delayed write-address path. It owns every RAM FFT-side signal while the RAM is in FFT mode (`mode` = 0).

## Interface
- `N_LOG2`, 10, log2 of frame length N; legal range 1..11
- `ADDR_W`, 12, RAM address width
- `SCRATCH_ADDR`, 4095, sacrificial address that the RAM writes to whenever no real write is pending
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begins a frame when the block is idle; ignored while `busy`
- `bitrev`  in  1  read order select, latched at start; 1 = bit-reversed
- `in_base`  in  ADDR_W  sample base address, latched at start
- `out_base`  in  ADDR_W  result base address, latched at start
- `busy`  out  1  high from the cycle after an accepted start until `done`
- `done`  out  1  one-cycle pulse at frame end
- `ram_read_addr`  out  ADDR_W  to RAM `READ_ADDRESS`
- `ram_write_to_cache`  out  1  to RAM `write_to_cache`; 1 = read this cycle, which inhibits the RAM write
- `ram_read_data`  in  16  from RAM `READ_DATA`; valid the cycle after the read is issued
- `ram_send_addr`  out  ADDR_W  to RAM `SEND_ADDR`
- `ram_send_data`  out  32  to RAM `SEND_DATA`
- `smp_data` / `smp_valid`  out  16 / 1  sample stream to the core
- `smp_ready`  in  1  sample stream acceptance from the core
- `res_data` / `res_valid`  in  32 / 1  result stream from the core
- `res_ready`  out  1  result stream acceptance to the core

## Operation
- States: IDLE, LOAD, STORE, FLUSH.
- IDLE -> LOAD when `start` = 1. On that edge, latch `bitrev`, `in_base` and `out_base`, and clear the counters.
- LOAD:
  - Read counter rk runs 0..N-1.
  - Address = `in_base` + (`bitrev` ? reverse of the low N_LOG2 bits of rk : rk), modulo 2^ADDR_W.
  - A read is issued (`ram_write_to_cache` = 1, rk increments) when rk < N and occupancy + inflight < 3. The skid FIFO is 3 deep; inflight is 0 or 1.
  - `ram_read_data` is pushed into the FIFO the cycle after the read is issued.
  - `smp_valid` = FIFO not empty; pop on `smp_valid` && `smp_ready`. Samples come out in issue order.
  - LOAD -> STORE when N samples have been popped.
- STORE:
  - `res_ready` = 1.
  - On a handshake at cycle t with write counter wk: `ram_send_addr` = `out_base` + wk (wraps) in cycle t, and `ram_send_data` = that `res_data` in cycle t+2 through a 2-stage data pipe. This matches the RAM's internal 2-flop address delay.
  - STORE -> FLUSH after the N-th handshake.
- FLUSH: 2 cycles. Then `done` pulses, state returns to IDLE and `busy` falls.
- Write safety:
  - In every cycle with no result handshake (all states), `ram_send_addr` = `SCRATCH_ADDR`.
  - `ram_write_to_cache` is 0 outside LOAD and 0 in LOAD cycles with no read issued.
  - `res_ready` = 0 outside STORE. Results presented during LOAD are back-pressured and never dropped.
  - Reads and writes never overlap, because no read is issued in STORE or FLUSH.
- `ram_send_data` = 0 whenever no pipelined write is due.
- Reset (any time, including mid-frame): state IDLE, counters and FIFO cleared, in-flight data discarded. Reset values:
  - `busy`, `done`, `smp_valid`, `res_ready`, `ram_write_to_cache` = 0
  - `ram_read_addr` = 0, `ram_send_addr` = `SCRATCH_ADDR`, `ram_send_data` = 0, `smp_data` = 0
- `start` asserted while busy has no effect.

## Timing
- Start sampled at edge 0. First read issued in cycle 1, data visible in cycle 2, `smp_valid` first high in cycle 3.
- With `smp_ready` held at 1: one read and one sample per cycle; the last sample is popped in cycle N+2.
- Backpressure: at most 3 samples are buffered or in flight. Reads stall until the count drops below 3.
- Write latency: result handshake at t -> RAM commits at the edge ending t+2.
- `done` is high in cycle tl+3, where tl = last result handshake; `busy` = 0 from tl+4.
- `res_ready` is high from the first STORE cycle; throughput is one result per cycle.

## Test plan
- Natural order: N_LOG2=3, `in_base`=0x100, `bitrev`=0, `smp_ready`=1 -> `ram_read_addr` 0x100..0x107 in cycles 1..8 with `ram_write_to_cache`=1; `smp_valid` in cycles 3..10 carrying MEM[0x100..0x107] in order.
- Bit-reversed: N_LOG2=3, `in_base`=0, `bitrev`=1 -> read addresses 0,4,2,6,1,5,3,7.
- Backpressure: `smp_ready`=0 in cycles 4..9 -> no more than 3 samples outstanding, `ram_write_to_cache`=0 while stalled, all 8 samples delivered in order with no duplicates.
- Store with wrap: `out_base`=0xFFE, 8 results 0xA0..0xA7 -> MEM[0xFFE,0xFFF,0x000..0x005] = 0xA0..0xA7; idle cycles drive `SCRATCH_ADDR`; `done` pulses 3 cycles after the last handshake.
- Result held early: `res_valid`=1 during LOAD -> `res_ready` stays 0 until STORE, and no RAM write lands outside `SCRATCH_ADDR` before STORE.
- Reset mid-LOAD at rk=4 -> all outputs take reset values next cycle; a new `start` reads from offset 0; `start` pulses during `busy` are ignored.
